// File: rtl/pc_fetch_unit.sv
// Program counter owner and two-beat big-endian instruction fetcher over a
// byte-wide memory port; holds each instruction until decode retires it.
module pc_fetch_unit #(
  parameter int              PC_W     = 11,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] write_data_PC,
  input  logic            instr_ready,
  output logic [PC_W-1:0] read_PC,
  output logic [15:0]     instr,
  output logic            instr_valid,
  output logic            imem_req,
  output logic [PC_W:0]   imem_addr,
  input  logic [7:0]      imem_data,
  input  logic            imem_ack
);

  // state    | meaning
  // IDLE     | settle cycle after reset, no request
  // FETCH_HI | requesting even byte -> instr[15:8]
  // FETCH_LO | requesting odd byte  -> instr[7:0]
  // VALID    | instr held for decode until instr_ready
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FETCH_HI = 2'd1;
  localparam logic [1:0] FETCH_LO = 2'd2;
  localparam logic [1:0] VALID    = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  logic            valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: state_d = FETCH_HI;
      FETCH_HI: begin
        if (imem_ack) begin
          instr_d[15:8] = imem_data;
          state_d       = FETCH_LO;
        end
      end
      FETCH_LO: begin
        if (imem_ack) begin
          instr_d[7:0] = imem_data;
          valid_d      = 1'b1;
          state_d      = VALID;
        end
      end
      VALID: begin
        if (instr_ready) begin
          pc_d    = write_data_PC;
          valid_d = 1'b0;
          state_d = FETCH_HI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Request and address decode from registered state only, so ack has no path to them.
  assign imem_req    = (state_q == FETCH_HI) || (state_q == FETCH_LO);
  assign imem_addr   = imem_req ? {pc_q, (state_q == FETCH_LO)} : '0;
  assign read_PC     = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit: a memory responder with
// configurable wait states, a monitor that checks each delivered instruction.
module tb_pc_fetch_unit;
  localparam int          PC_W     = 11;
  localparam logic [10:0] RESET_PC = 11'h000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] write_data_PC = '0;
  logic        instr_ready = 1'b0;
  logic [10:0] read_PC;
  logic [15:0] instr;
  logic        instr_valid;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic [7:0]  imem_data = '0;
  logic        imem_ack = 1'b0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .write_data_PC(write_data_PC),
    .instr_ready(instr_ready), .read_PC(read_PC), .instr(instr),
    .instr_valid(instr_valid), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_ack(imem_ack)
  );

  typedef struct packed {
    logic [10:0] pc;
    logic [15:0] ins;
  } exp_t;

  logic [7:0] mem [4096];
  exp_t       sbq[$];
  int         n_checks = 0;
  int         n_err = 0;
  int         fixed_wait = 0;
  int         max_wait = 3;
  bit         stray_en = 1'b0;

  // Reference: instruction at pc is the byte pair at 2*pc (high) and 2*pc+1 (low).
  function automatic exp_t expect_at(logic [10:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = {mem[{pc, 1'b0}], mem[{pc, 1'b1}]};
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder; also checks that an unanswered request stays put.
  int         wait_left = 0;
  logic       prev_req = 1'b0;
  logic       prev_ack = 1'b0;
  logic [11:0] prev_addr = '0;
  always @(negedge clk) begin
    if (imem_req && prev_req && !prev_ack)
      chk("req_addr_stable", int'(imem_addr), int'(prev_addr));
    if (imem_req) begin
      if (!prev_req || prev_ack)
        wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, max_wait));
      if (wait_left == 0) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
      end else begin
        imem_ack  = 1'b0;
        imem_data = 8'($urandom);
        wait_left--;
      end
    end else begin
      imem_ack  = stray_en;
      imem_data = 8'hA5;
    end
    prev_req  = imem_req;
    prev_ack  = imem_ack;
    prev_addr = imem_addr;
  end

  // Monitor: pop on each new instruction, then require it to hold while valid.
  logic        prev_valid = 1'b0;
  exp_t        held;
  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_instr", 1, 0);
      end else begin
        held = sbq.pop_front();
        chk("sb_read_PC", int'(read_PC), int'(held.pc));
        chk("sb_instr", int'(instr), int'(held.ins));
      end
    end else if (instr_valid && prev_valid) begin
      chk("hold_read_PC", int'(read_PC), int'(held.pc));
      chk("hold_instr", int'(instr), int'(held.ins));
    end
    prev_valid = instr_valid;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(string name);
    int n = 0;
    while (!instr_valid && n < 200) begin
      step();
      n++;
    end
    chk(name, int'(instr_valid), 1);
  endtask

  task automatic retire(logic [10:0] pc);
    instr_ready   = 1'b1;
    write_data_PC = pc;
    sbq.push_back(expect_at(pc));
    step();
    instr_ready   = 1'b0;
    write_data_PC = 11'($urandom);
  endtask

  initial begin
    int   n;
    exp_t e;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h12;
    mem[1] = 8'h34;

    // Reset state and zero-wait first fetch
    fixed_wait = 0;
    reset = 1'b1;
    step();
    step();
    chk("rst_read_PC", int'(read_PC), int'(RESET_PC));
    chk("rst_instr", int'(instr), 0);
    chk("rst_valid", int'(instr_valid), 0);
    chk("rst_req", int'(imem_req), 0);
    chk("rst_addr", int'(imem_addr), 0);
    reset = 1'b0;
    sbq.push_back(expect_at(RESET_PC));
    chk("idle_req", int'(imem_req), 0);
    step();
    chk("hi_req", int'(imem_req), 1);
    chk("hi_addr", int'(imem_addr), 12'h000);
    step();
    chk("lo_addr", int'(imem_addr), 12'h001);
    step();
    chk("first_valid", int'(instr_valid), 1);
    chk("first_instr", int'(instr), 16'h1234);

    // Three wait states per byte: valid 8 cycles after FETCH_HI entry
    fixed_wait = 3;
    retire(11'h0A0);
    chk("w3_req", int'(imem_req), 1);
    chk("w3_addr", int'(imem_addr), 12'h140);
    n = 0;
    while (!instr_valid && n < 50) begin
      step();
      n++;
    end
    chk("w3_latency", n, 8);

    // Long hold in VALID with stray acks, then retire to 0x155
    fixed_wait = 0;
    stray_en = 1'b1;
    e = expect_at(11'h0A0);
    repeat (10) begin
      step();
      chk("hold10_valid", int'(instr_valid), 1);
      chk("hold10_instr", int'(instr), int'(e.ins));
      chk("hold10_pc", int'(read_PC), 11'h0A0);
    end
    stray_en = 1'b0;
    retire(11'h155);
    chk("ret155_pc", int'(read_PC), 11'h155);
    chk("ret155_addr", int'(imem_addr), 12'h2AA);
    wait_valid("ret155_valid");

    // Top of the address space, then back to zero
    retire(11'h7FF);
    chk("wrap_addr_hi", int'(imem_addr), 12'hFFE);
    step();
    chk("wrap_addr_lo", int'(imem_addr), 12'hFFF);
    step();
    chk("wrap_valid", int'(instr_valid), 1);
    retire(11'h000);
    chk("zero_addr_hi", int'(imem_addr), 12'h000);
    step();
    chk("zero_addr_lo", int'(imem_addr), 12'h001);
    wait_valid("zero_valid");

    // Reset during FETCH_LO with stray acks through reset and IDLE
    fixed_wait = 2;
    retire(11'h321);
    n = 0;
    while (!(imem_req && imem_addr[0]) && n < 20) begin
      step();
      n++;
    end
    chk("midrst_in_lo", int'(imem_addr), 12'h643);
    reset = 1'b1;
    stray_en = 1'b1;
    sbq.delete();
    step();
    chk("midrst_instr", int'(instr), 0);
    chk("midrst_req", int'(imem_req), 0);
    chk("midrst_valid", int'(instr_valid), 0);
    chk("midrst_pc", int'(read_PC), int'(RESET_PC));
    reset = 1'b0;
    sbq.push_back(expect_at(RESET_PC));
    step();
    stray_en = 1'b0;
    chk("refetch_req", int'(imem_req), 1);
    chk("refetch_addr", int'(imem_addr), 12'h000);
    chk("refetch_instr", int'(instr), 0);
    wait_valid("refetch_valid");

    // Reset and retire together in VALID
    step();
    reset = 1'b1;
    instr_ready = 1'b1;
    write_data_PC = 11'h0AB;
    sbq.delete();
    step();
    chk("rstret_pc", int'(read_PC), int'(RESET_PC));
    chk("rstret_valid", int'(instr_valid), 0);
    chk("rstret_instr", int'(instr), 0);
    reset = 1'b0;
    instr_ready = 1'b0;
    sbq.push_back(expect_at(RESET_PC));
    wait_valid("rstret_refetch");

    // instr_ready pulses while fetching must not move the PC
    fixed_wait = 3;
    retire(11'h2C3);
    repeat (3) begin
      instr_ready = 1'b1;
      write_data_PC = 11'($urandom);
      step();
      chk("fetch_ready_pc", int'(read_PC), 11'h2C3);
    end
    instr_ready = 1'b0;
    wait_valid("fetch_ready_valid");

    // Randomized traffic
    fixed_wait = -1;
    repeat (40) begin
      wait_valid("rand_valid");
      stray_en = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) step();
      stray_en = 1'b0;
      retire(11'($urandom));
    end
    wait_valid("rand_last_valid");
    step();
    chk("sb_drain", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Owns the 11-bit program counter and fetches 16-bit instructions from byte-wide instruction memory. It is the consumer of the next-PC value from the PC-source mux. It publishes read_PC and the assembled instr to decode and the PC mux. It updates the PC from write_data_PC only when decode retires the current instruction.

Parameters:
PC_W, 11, program counter width; byte address width is PC_W+1
RESET_PC, 11'h000, PC value loaded by reset

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
write_data_PC  input  PC_W  next PC from PC-source mux; sampled only on retire
instr_ready  input  1  decode retires current instruction this cycle
read_PC  output  PC_W  PC of the instruction currently held or being fetched
instr  output  16  assembled instruction; stable while instr_valid=1
instr_valid  output  1  instr holds a complete instruction for read_PC
imem_req  output  1  memory read request
imem_addr  output  PC_W+1  byte address {read_PC, byte_sel}
imem_data  input  8  read data, valid when imem_ack=1
imem_ack  input  1  memory completes current request this cycle

Behaviour:
- Reset (sync, active-high; dominates all other inputs):
  - read_PC=RESET_PC, instr=16'h0000, instr_valid=0, imem_req=0, imem_addr=0.
  - FSM goes to IDLE.
- FSM states: IDLE, FETCH_HI, FETCH_LO, VALID.
- IDLE: one cycle after reset, then FETCH_HI. imem_req=0.
- FETCH_HI:
  - imem_req=1, imem_addr={read_PC,1'b0}.
  - On a cycle with imem_ack=1: instr[15:8]<=imem_data, go to FETCH_LO.
  - Otherwise hold req/addr stable (no request withdrawal).
- FETCH_LO:
  - imem_req=1, imem_addr={read_PC,1'b1}.
  - On ack: instr[7:0]<=imem_data, go to VALID.
- Byte order is big-endian: the even byte is instr[15:8].
- VALID:
  - imem_req=0, instr_valid=1; instr and read_PC held stable.
  - On instr_ready=1: read_PC<=write_data_PC, instr_valid<=0, go to FETCH_HI next cycle.
- instr_ready outside VALID is ignored; the PC never changes except on retire or reset.
- imem_ack while imem_req=0 (IDLE, VALID, or the cycle after reset) is ignored. No state or data change.
- Ack may arrive combinationally in the same cycle as req assertion. Minimum latency from entering FETCH_HI to instr_valid=1 is 2 cycles. Each ack wait cycle adds 1 cycle.
- Retire-to-next-fetch: read_PC takes the new value the cycle after instr_ready. imem_addr reflects it in that same cycle.
- Zero-cycle retire (ready high on the first VALID cycle) is legal. Instruction throughput is 1 per 3 cycles with zero-wait memory.
- write_data_PC is taken verbatim, with no arithmetic in this block. Wrap (7FF+1=000) and branch offsets are the mux's responsibility.
- At PC 7FF, fetch addresses are FFE then FFF. There is no special case.
- Reset mid-fetch (FETCH_HI/LO):
  - The fetch is abandoned; imem_req=0 the next cycle.
  - A late ack from the abandoned request is ignored in IDLE.
  - A partial instr is discarded (cleared to 0).
- Reset in VALID with instr_ready=1 simultaneously: reset wins; read_PC=RESET_PC, not write_data_PC.
- instr_valid is a registered output; instr bits are registered. There are no combinational input-to-output paths except none.

Test Plan:
- Reset release, zero-wait memory with bytes 0x12,0x34 at 0x000/0x001:
  - Expected: imem_addr=000 then 001, instr_valid=1 with instr=0x1234, read_PC=0x000 in the third cycle after IDLE.
- Memory ack delayed 3 cycles per byte:
  - Expected: req/addr held stable throughout.
  - Expected: instr_valid asserts exactly 8 cycles after FETCH_HI entry, instr correct.
- Hold instr_ready=0 for 10 cycles in VALID, then pulse with write_data_PC=0x155:
  - Expected: instr/read_PC unchanged for 10 cycles.
  - Expected: next cycle read_PC=0x155, imem_addr=0x2AA.
- Retire with write_data_PC=0x7FF, then retire again with write_data_PC=0x000:
  - Expected: fetch addresses 0xFFE, 0xFFF, then 0x000, 0x001; no X or overflow.
- Assert reset during FETCH_LO after high byte latched, with a stray ack arriving in IDLE:
  - Expected: instr=0x0000, req=0 next cycle, stray ack ignored.
  - Expected: refetch starts at RESET_PC.
- Reset and instr_ready both high in VALID with write_data_PC=0x0AB:
  - Expected: read_PC=RESET_PC, instr_valid=0.
- Spurious imem_ack pulses in VALID and instr_ready pulses during FETCH_HI:
  - Expected: no change to instr, read_PC, or state.
